// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: next-PC select encodings (also used by decode
// control) and default widths for the IF stage.
package fetch_pkg;

  localparam int PC_W   = 7;
  localparam int INSN_W = 32;

  localparam logic [31:0] INSN_NOP = 32'd0;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'd0,
    PCSRC_BR  = 2'd1,
    PCSRC_J   = 2'd2,
    PCSRC_JR  = 2'd3
  } pcsrc_e;

endpackage

// File: rtl/fetch_if.sv
// Synchronous instruction-memory port: address out, read data back one cycle later.
interface fetch_if #(
  parameter int PC_W   = 7,
  parameter int INSN_W = 32
);
  logic [PC_W-1:0]   imem_addr;
  logic [INSN_W-1:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: reset, then stall hold, then decode redirect, then pc+1.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic [1:0]      pcsrc_i,
  input  logic [PC_W-1:0] pc_q_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic [PC_W-1:0] j_target_i,
  input  logic [PC_W-1:0] jr_target_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic            redirect_o
);

  always_comb begin
    pc_next_o  = pc_q_i + PC_W'(1);
    redirect_o = 1'b0;
    if (rst_i) begin
      pc_next_o = RESET_PC;
    end else if (stall_i) begin
      // A redirect arriving during a stall is dropped; the hazard unit re-presents it.
      pc_next_o = pc_q_i;
    end else begin
      unique case (pcsrc_e'(pcsrc_i))
        PCSRC_SEQ: pc_next_o = pc_q_i + PC_W'(1);
        PCSRC_BR:  pc_next_o = br_target_i;
        PCSRC_J:   pc_next_o = j_target_i;
        PCSRC_JR:  pc_next_o = jr_target_i;
        default:   pc_next_o = pc_q_i + PC_W'(1);
      endcase
      redirect_o = (pcsrc_e'(pcsrc_i) != PCSRC_SEQ);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the synchronous instruction ROM and presents
// the fetched word plus bring-up stall/redirect counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter int              INSN_W   = fetch_pkg::INSN_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic [1:0]        PCSrcD,
  input  logic [PC_W-1:0]   BranchTargetD,
  input  logic [PC_W-1:0]   JumpTargetD,
  input  logic [PC_W-1:0]   RegTargetD,
  fetch_if.master           imem,
  output logic [INSN_W-1:0] ins,
  output logic [PC_W-1:0]   PC_plus1F,
  output logic              insValidF,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redir_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
  endfunction

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic             redirect;

  fetch_next_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_next_pc (
    .rst_i       (rst),
    .stall_i     (StallF),
    .pcsrc_i     (PCSrcD),
    .pc_q_i      (pc_q),
    .br_target_i (BranchTargetD),
    .j_target_i  (JumpTargetD),
    .jr_target_i (RegTargetD),
    .pc_next_o   (pc_d),
    .redirect_o  (redirect)
  );

  always_comb begin
    valid_d     = 1'b1;
    stall_cnt_d = sat_inc(stall_cnt_q, StallF);
    redir_cnt_d = sat_inc(redir_cnt_q, redirect);
  end

  // pc_q always names the word currently on imem_rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign imem.imem_addr = pc_d;
  assign ins            = valid_q ? imem.imem_rdata : INSN_W'(INSN_NOP);
  assign PC_plus1F      = pc_q + PC_W'(1);
  assign insValidF      = valid_q;
  assign stall_cnt      = stall_cnt_q;
  assign redir_cnt      = redir_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage driving a behavioural synchronous ROM.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic [1:0]  PCSrcD;
  logic [6:0]  BranchTargetD, JumpTargetD, RegTargetD;
  logic [31:0] ins;
  logic [6:0]  PC_plus1F;
  logic        insValidF;
  logic [15:0] stall_cnt, redir_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic [6:0]  pcp1;
    logic        vld;
    logic [15:0] st;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  logic [6:0]  m_pc;
  logic [15:0] m_stall, m_redir;
  logic [31:0] rom [128];

  fetch_if #(.PC_W(7), .INSN_W(32)) imem ();

  fetch_stage #(.PC_W(7), .INSN_W(32), .RESET_PC(7'd0), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .PCSrcD        (PCSrcD),
    .BranchTargetD (BranchTargetD),
    .JumpTargetD   (JumpTargetD),
    .RegTargetD    (RegTargetD),
    .imem          (imem.master),
    .ins           (ins),
    .PC_plus1F     (PC_plus1F),
    .insValidF     (insValidF),
    .stall_cnt     (stall_cnt),
    .redir_cnt     (redir_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem.imem_rdata <= rom[imem.imem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; StallF = 1'b0; PCSrcD = 2'd0;
    BranchTargetD = 7'd0; JumpTargetD = 7'd0; RegTargetD = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_addr", imem.imem_addr, 32'd0);
    check_val("rst_ins", ins, 32'd0);
    check_val("rst_valid", insValidF, 32'd0);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_redir_cnt", redir_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst_addr", imem.imem_addr, 32'd1);
    check_val("post_rst_ins", ins, 32'd0);
    check_val("post_rst_valid", insValidF, 32'd0);
    check_val("post_rst_pcp1", PC_plus1F, 32'd1);
    m_pc = 7'd0; m_stall = 16'd0; m_redir = 16'd0;
  endtask

  // One fetch cycle: drive, predict, let the edge happen, then score the output.
  task automatic step(input logic st, input logic [1:0] src, input logic [6:0] tgt);
    logic [6:0] nxt;
    exp_t e;
    StallF = st; PCSrcD = src;
    BranchTargetD = (src == 2'd1) ? tgt : tgt ^ 7'h55;
    JumpTargetD   = (src == 2'd2) ? tgt : tgt ^ 7'h2A;
    RegTargetD    = (src == 2'd3) ? tgt : tgt ^ 7'h63;
    if (st) nxt = m_pc;
    else if (src == 2'd0) nxt = m_pc + 7'd1;
    else nxt = tgt;
    #1 check_val("imem_addr", imem.imem_addr, nxt);
    if (st && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (!st && src != 2'd0) m_redir = m_redir + 16'd1;
    m_pc = nxt;
    e.ins = rom[nxt]; e.pcp1 = nxt + 7'd1; e.vld = 1'b1; e.st = m_stall; e.rd = m_redir;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("ins", ins, e.ins);
    check_val("pc_plus1", PC_plus1F, e.pcp1);
    check_val("valid", insValidF, e.vld);
    check_val("stall_cnt", stall_cnt, e.st);
    check_val("redir_cnt", redir_cnt, e.rd);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 + i;

    // Reset, then the sequential stream resumes at 1 (word 0 is the NOP slot)
    do_reset();
    step(1'b0, 2'd0, 7'd0);
    check_val("first_ins", ins, 32'h1000_0001);

    // Sequential wrap across 127 -> 0
    step(1'b0, 2'd2, 7'd125);
    step(1'b0, 2'd0, 7'd0);
    step(1'b0, 2'd0, 7'd0);
    check_val("wrap_pcp1", PC_plus1F, 32'd0);
    step(1'b0, 2'd0, 7'd0);
    check_val("wrap_ins0", ins, 32'h1000_0000);
    step(1'b0, 2'd0, 7'd0);

    // Stall three cycles at pc 5, with a redirect request ignored mid-stall
    step(1'b0, 2'd2, 7'd5);
    step(1'b1, 2'd0, 7'd0);
    step(1'b1, 2'd1, 7'd33);
    step(1'b1, 2'd0, 7'd0);
    check_val("stall_hold_ins", ins, 32'h1000_0005);
    check_val("stall_cnt3", stall_cnt, 32'd3);
    step(1'b0, 2'd0, 7'd0);
    check_val("after_stall_ins", ins, 32'h1000_0006);

    // Redirects of each kind from a fresh reset
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 7'd0);
    step(1'b0, 2'd1, 7'd40);
    check_val("br_ins", ins, 32'h1000_0028);
    check_val("br_pcp1", PC_plus1F, 32'd41);
    check_val("br_redir", redir_cnt, 32'd1);
    step(1'b0, 2'd2, 7'd80);
    check_val("j_ins", ins, 32'h1000_0050);
    step(1'b0, 2'd3, 7'd3);
    check_val("jr_ins", ins, 32'h1000_0003);
    check_val("jr_redir", redir_cnt, 32'd3);

    // Jump presented during a stall is held off, then taken
    step(1'b1, 2'd2, 7'd90);
    check_val("stalled_j_redir", redir_cnt, 32'd3);
    step(1'b0, 2'd2, 7'd90);
    check_val("late_j_ins", ins, 32'h1000_005A);

    // Stall counter saturation, then reset in the middle of a stall
    do_reset();
    StallF = 1'b1; PCSrcD = 2'd0;
    repeat (16'hFFFE) @(posedge clk);
    #1;
    check_val("stall_cnt_fffe", stall_cnt, 32'h0000_FFFE);
    m_stall = 16'hFFFE;
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 7'd0);
    check_val("stall_cnt_sat", stall_cnt, 32'h0000_FFFF);

    rst = 1'b1; StallF = 1'b1; PCSrcD = 2'd2; JumpTargetD = 7'd90;
    #1 check_val("midstall_rst_addr", imem.imem_addr, 32'd0);
    @(posedge clk);
    #1;
    check_val("midstall_stall_cnt", stall_cnt, 32'd0);
    check_val("midstall_redir_cnt", redir_cnt, 32'd0);
    check_val("midstall_valid", insValidF, 32'd0);
    check_val("midstall_pcp1", PC_plus1F, 32'd1);
    @(negedge clk);
    rst = 1'b0; StallF = 1'b0; PCSrcD = 2'd0;
    m_pc = 7'd0; m_stall = 16'd0; m_redir = 16'd0;
    step(1'b0, 2'd0, 7'd0);
    check_val("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
